// File: rtl/qam16_pkg.sv
// qam16_pkg: shared constants and types for the QAM16 mapper.
// Sample width, FSM states and Gray-coded level indices.
package qam16_pkg;

    localparam int SAMPLE_W = 14;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] GRAY_M3 = 2'b00;
    localparam logic [1:0] GRAY_M1 = 2'b01;
    localparam logic [1:0] GRAY_P1 = 2'b11;
    localparam logic [1:0] GRAY_P3 = 2'b10;

endpackage

// File: rtl/qam16_gray_lut.sv
// qam16_gray_lut: Gray-coded 2-bit pair to signed amplitude level.
// Levels are -3A, -A, +A, +3A in two's complement.
module qam16_gray_lut
    import qam16_pkg::*;
#(
    parameter int AMP = 2048
) (
    input  logic [1:0]                 code,
    output logic signed [SAMPLE_W-1:0] level
);

    localparam logic signed [SAMPLE_W-1:0] LVL1 = SAMPLE_W'(AMP);
    localparam logic signed [SAMPLE_W-1:0] LVL3 = SAMPLE_W'(3 * AMP);

    // Map the Gray pair onto its constellation level
    always_comb begin
        level = '0;
        unique case (code)
            GRAY_M3: level = -LVL3;
            GRAY_M1: level = -LVL1;
            GRAY_P1: level = LVL1;
            GRAY_P3: level = LVL3;
            default: level = '0;
        endcase
    end

endmodule

// File: rtl/qam16_mapper.sv
// qam16_mapper: serial bits to zero-stuffed QAM16 I/Q samples.
// Packs 4 bits per symbol, emits one symbol every SPS cycles.
module qam16_mapper
    import qam16_pkg::*;
#(
    parameter int SPS = 8,
    parameter int AMP = 2048
) (
    input  logic                       CLK,
    input  logic                       Rst,
    input  logic                       i_bit,
    input  logic                       i_bit_vld,
    output logic                       o_bit_rdy,
    output logic signed [SAMPLE_W-1:0] o_I,
    output logic signed [SAMPLE_W-1:0] o_Q,
    output logic                       o_sym_stb,
    output logic                       o_underrun,
    output logic                       o_busy
);

    localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);

    state_e                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [2:0]                 asm_q, asm_d;
    logic [1:0]                 bc_q, bc_d;
    logic [3:0]                 hold_q, hold_d;
    logic                       hold_vld_q, hold_vld_d;
    logic                       rdy_q, rdy_d;
    logic signed [SAMPLE_W-1:0] i_q, i_d;
    logic signed [SAMPLE_W-1:0] q_q, q_d;
    logic                       stb_q, stb_d;
    logic                       und_q, und_d;
    logic                       busy_q, busy_d;

    logic                       accept;
    logic                       load;
    logic                       phase0;
    logic                       consume;
    logic signed [SAMPLE_W-1:0] lvl_i;
    logic signed [SAMPLE_W-1:0] lvl_q;

    qam16_gray_lut #(.AMP(AMP)) u_lut_i (
        .code  (hold_q[3:2]),
        .level (lvl_i)
    );

    qam16_gray_lut #(.AMP(AMP)) u_lut_q (
        .code  (hold_q[1:0]),
        .level (lvl_q)
    );

    // Next-state: bit assembly, hold register, phase FSM, outputs
    always_comb begin
        accept  = i_bit_vld && rdy_q;
        load    = accept && (bc_q == 2'd3);
        phase0  = (state_q == IDLE) || (cnt_q == '0);
        consume = hold_vld_q && phase0;

        asm_d      = asm_q;
        bc_d       = bc_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        state_d    = state_q;
        cnt_d      = cnt_q;

        if (accept) begin
            asm_d = {asm_q[1:0], i_bit};
            bc_d  = load ? 2'd0 : bc_q + 2'd1;
        end

        // Consume reads the old hold; a same-edge load then refills it
        if (consume) begin
            hold_vld_d = 1'b0;
        end
        if (load) begin
            hold_d     = {asm_q, i_bit};
            hold_vld_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (hold_vld_q) begin
                    state_d = RUN;
                    cnt_d   = CW'(1);
                end
            end
            RUN: begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        i_d    = consume ? lvl_i : '0;
        q_d    = consume ? lvl_q : '0;
        stb_d  = consume;
        und_d  = (state_q == RUN) && (cnt_q == '0) && !hold_vld_q;
        busy_d = (state_d == RUN);
        rdy_d  = !(hold_vld_d && (bc_d == 2'd3));
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!Rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            asm_q      <= '0;
            bc_q       <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
            i_q        <= '0;
            q_q        <= '0;
            stb_q      <= 1'b0;
            und_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            bc_q       <= bc_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            rdy_q      <= rdy_d;
            i_q        <= i_d;
            q_q        <= q_d;
            stb_q      <= stb_d;
            und_q      <= und_d;
            busy_q     <= busy_d;
        end
    end

    assign o_bit_rdy  = rdy_q;
    assign o_I        = i_q;
    assign o_Q        = q_q;
    assign o_sym_stb  = stb_q;
    assign o_underrun = und_q;
    assign o_busy     = busy_q;

endmodule

// File: doc/qam16_mapper.md
# qam16_mapper

Upstream stage of the QAM16 transmit chain, feeding the pulse-shaping filter and DAC path whose outputs drive DA/DB. It accepts a serial bit stream under a valid/ready handshake and packs 4 bits per symbol. Each symbol is Gray-mapped to signed 14-bit I/Q levels. Symbols are emitted as a zero-stuffed stream at SPS samples per symbol, with a symbol strobe and an underrun flag.

## Interface
- SPS, 8: samples per symbol; legal range 4..64.
- AMP, 2048: unit amplitude; levels are ±AMP and ±3·AMP; 3·AMP must be ≤ 8191.
- CLK  in  1  system/sample clock; one output sample per cycle.
- Rst  in  1  reset. One clock; reset is synchronous and active-low.
- i_bit  in  1  serial data bit.
- i_bit_vld  in  1  i_bit valid.
- o_bit_rdy  out  1  bit accepted on an edge where i_bit_vld && o_bit_rdy.
- o_I  out  14  signed I sample; symbol level or 0.
- o_Q  out  14  signed Q sample; symbol level or 0.
- o_sym_stb  out  1  high on the sample carrying a symbol (phase 0).
- o_underrun  out  1  one-cycle pulse: phase 0 reached in RUN with no symbol held.
- o_busy  out  1  high in state RUN.

## Operation
- Assembly: shift register asm[2:0] plus bit count bc (0..3). The first accepted bit is b3, the last is b0.
- When the 4th bit is accepted:
  - hold <= {asm, i_bit};
  - hold_vld <= 1;
  - bc <= 0.
- o_bit_rdy = !(hold_vld && bc==3). Up to 3 bits of the next symbol may be collected while hold is full.
- Gray map per 2-bit pair: 00→-3·AMP, 01→-1·AMP, 11→+1·AMP, 10→+3·AMP.
  - I uses b3b2; Q uses b1b0.
  - Two's complement, 14 bits.
- FSM IDLE / RUN:
  - IDLE: phase counter cnt held at 0. Outputs are 0, no underrun pulses. On an edge with hold_vld=1: emit the symbol (o_I/o_Q = map, o_sym_stb=1), clear hold_vld, cnt<=1, go to RUN.
  - RUN: every edge, cnt <= (cnt==SPS-1) ? 0 : cnt+1.
    - When cnt==0 and hold_vld: emit symbol, o_sym_stb=1, clear hold_vld.
    - When cnt==0 and !hold_vld: o_I/o_Q=0, o_sym_stb=0, o_underrun=1 for one cycle. Stay in RUN.
    - When cnt!=0: o_I/o_Q=0, o_sym_stb=0.
- RUN is left only by reset.
- Simultaneous load and consume cannot occur, because ready is low whenever the 4th bit would collide with a full hold. An implementation must not rely on this; consume has priority.

## Timing
- All outputs registered.
- Reset value of every output: o_I=0, o_Q=0, o_sym_stb=0, o_underrun=0, o_busy=0. o_bit_rdy=1 one cycle after Rst deasserts.
- Reset internal state: asm=0, bc=0, hold_vld=0, cnt=0, state IDLE.
- Reset mid-operation: the partially assembled and held symbols are discarded; the next Rst-high edge starts from IDLE.
- Latency: the 4th bit accepted at edge k → hold_vld from edge k. From IDLE, the symbol is on o_I/o_Q with o_sym_stb after edge k+1.
- Symbol period in RUN is exactly SPS cycles. o_sym_stb and o_underrun are mutually exclusive and both occur only at cnt==0.
- Sustained throughput: 4 bits per SPS cycles; the source must present bits at least that fast to avoid underrun.

## Structure
- Package qam16_pkg holds:
  - the 14-bit sample width constant;
  - the FSM state enum (IDLE, RUN);
  - the Gray-code 2-bit constants.
- Sub-module qam16_gray_lut: combinational 2-bit code plus AMP → signed 14-bit level. Instantiate it twice (I and Q).

## Test plan
- Reset: hold Rst=0 for 5 cycles with i_bit_vld=1 → all outputs 0, no bits accepted; o_bit_rdy=1 after release.
- Single symbol (SPS=8, AMP=2048): bits 1,0,0,1 on consecutive edges → one cycle later o_I=6144, o_Q=-2048, o_sym_stb=1; next 7 samples are 0; o_busy=1.
- All 16 codes streamed continuously → each strobe exactly 8 cycles apart; levels match the Gray table (e.g. 0000→-6144/-6144, 1111→+2048/+2048); no o_underrun.
- Stall the source after the first symbol → at the next phase 0, o_underrun pulses for 1 cycle with o_I=o_Q=0; it repeats every 8 cycles; resuming bits restores strobes on the phase-0 grid.
- Backpressure: with hold full and bc=3, o_bit_rdy=0 until the phase-0 consume edge, then returns to 1. No bit is lost or duplicated; check against a reference bit queue.
- Assert Rst mid-symbol (bc=2, hold_vld=1) → partial bits are dropped. The post-reset stream maps from the first new bit; the first strobe follows its 4th bit by 1 cycle.
